clct_drift_busy: RTL

CLCT_DRIFT_BUSY -- requirements
Module: clct_drift_busy

---
 rtl/pattern_params.sv | 17 +
 rtl/clct_drift_busy_if.sv | 34 +++
 rtl/busy_group_mask.sv | 18 +
 rtl/clct_drift_busy.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_params.sv
// Shared width constants and FSM state encoding for the CLCT drift/busy stage.
package pattern_params;

   localparam int MXPATB     = 7;   // pattern word: hits [6:4], pattern id [3:0]
   localparam int MXKEYBX    = 8;   // extended key: {group[2:0], key-in-group}
   localparam int MXBNDB     = 5;   // bend
   localparam int MXQLTB     = 6;   // quality
   localparam int MXPATC     = 12;  // carry
   localparam int MXSUBKEYBX = 10;  // 1/8-strip key

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIFT = 2'd1,
      S_HOLD  = 2'd2
   } clct_state_t;

endpackage

// File: rtl/clct_drift_busy_if.sv
// Sorter-to-CLCT bus: best-pattern inputs one way, emitted CLCT and busy mask back.
interface clct_drift_busy_if;
   import pattern_params::*;

   logic [MXPATB-1:0]     best_pat;
   logic [MXKEYBX-1:0]    best_key;
   logic [MXBNDB-1:0]     best_bend;
   logic [MXPATC-1:0]     best_carry;
   logic [MXSUBKEYBX-1:0] best_subkey;
   logic [MXQLTB-1:0]     best_qlt;
   logic                  best_bsy;

   logic                  clct_vld;
   logic [MXPATB-1:0]     clct_pat;
   logic [MXKEYBX-1:0]    clct_key;
   logic [MXBNDB-1:0]     clct_bend;
   logic [MXPATC-1:0]     clct_carry;
   logic [MXSUBKEYBX-1:0] clct_subkey;
   logic [MXQLTB-1:0]     clct_qlt;
   logic [6:0]            bsy_out;

   // Sorter side: drives the best candidate, receives CLCT and busy feedback
   modport master (
      output best_pat, best_key, best_bend, best_carry, best_subkey, best_qlt, best_bsy,
      input  clct_vld, clct_pat, clct_key, clct_bend, clct_carry, clct_subkey, clct_qlt, bsy_out
   );

   // CLCT stage side
   modport slave (
      input  best_pat, best_key, best_bend, best_carry, best_subkey, best_qlt, best_bsy,
      output clct_vld, clct_pat, clct_key, clct_bend, clct_carry, clct_subkey, clct_qlt, bsy_out
   );

endinterface

// File: rtl/busy_group_mask.sv
// Decodes a key group into a 3-wide busy mask (g-1, g, g+1), clipped to groups 0..6.
module busy_group_mask (
   input  logic [2:0] grp,
   output logic [6:0] mask
);

   logic [2:0] g;
   logic [6:0] center;

   // Clip group 7 onto group 6 and spread the one-hot centre to its neighbours
   always_comb begin
      g      = (grp > 3'd6) ? 3'd6 : grp;
      center = 7'd1 << g;
      // Shifting left past bit 6 drops naturally, which clips the top edge
      mask   = center | (center << 1) | (center >> 1);
   end

endmodule

// File: rtl/clct_drift_busy.sv
// CLCT drift/busy stage: holds the best qualified pattern open for drift_dly bx,
// emits it as a one-cycle strobe, then asserts per-group busy for busy_width bx.
module clct_drift_busy #(
   parameter int MXPATB     = pattern_params::MXPATB,
   parameter int MXKEYBX    = pattern_params::MXKEYBX,
   parameter int MXBNDB     = pattern_params::MXBNDB,
   parameter int MXQLTB     = pattern_params::MXQLTB,
   parameter int MXPATC     = pattern_params::MXPATC,
   parameter int MXSUBKEYBX = pattern_params::MXSUBKEYBX
) (
   input  logic                  clock,
   input  logic                  global_reset,
   input  logic [MXPATB-1:0]     best_pat,
   input  logic [MXKEYBX-1:0]    best_key,
   input  logic [MXBNDB-1:0]     best_bend,
   input  logic [MXPATC-1:0]     best_carry,
   input  logic [MXSUBKEYBX-1:0] best_subkey,
   input  logic [MXQLTB-1:0]     best_qlt,
   input  logic                  best_bsy,
   input  logic [2:0]            hit_thresh,
   input  logic [3:0]            pid_thresh,
   input  logic [2:0]            drift_dly,
   input  logic [3:0]            busy_width,
   output logic                  clct_vld,
   output logic [MXPATB-1:0]     clct_pat,
   output logic [MXKEYBX-1:0]    clct_key,
   output logic [MXBNDB-1:0]     clct_bend,
   output logic [MXPATC-1:0]     clct_carry,
   output logic [MXSUBKEYBX-1:0] clct_subkey,
   output logic [MXQLTB-1:0]     clct_qlt,
   output logic [6:0]            bsy_out,
   output logic [7:0]            lost_cnt
);
   import pattern_params::*;

   // Input stage
   logic [MXPATB-1:0]     r_pat;
   logic [MXKEYBX-1:0]    r_key;
   logic [MXBNDB-1:0]     r_bend;
   logic [MXPATC-1:0]     r_carry;
   logic [MXSUBKEYBX-1:0] r_subkey;
   logic [MXQLTB-1:0]     r_qlt;
   logic                  r_bsy;

   // Candidate held open during drift
   logic [MXPATB-1:0]     c_pat;
   logic [MXKEYBX-1:0]    c_key;
   logic [MXBNDB-1:0]     c_bend;
   logic [MXPATC-1:0]     c_carry;
   logic [MXSUBKEYBX-1:0] c_subkey;
   logic [MXQLTB-1:0]     c_qlt;

   // Candidate after this cycle's comparison
   logic [MXPATB-1:0]     nxt_pat;
   logic [MXKEYBX-1:0]    nxt_key;
   logic [MXBNDB-1:0]     nxt_bend;
   logic [MXPATC-1:0]     nxt_carry;
   logic [MXSUBKEYBX-1:0] nxt_subkey;
   logic [MXQLTB-1:0]     nxt_qlt;
   logic [6:0]            nxt_mask;

   clct_state_t state;
   logic [2:0]  drift_cnt;
   logic [3:0]  hold_cnt;
   logic        hit_ok;
   logic        better;
   logic        take;
   logic        emit;

   // Register every sorter output so qualification sees a stable word
   // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
   always_ff @(posedge clock) begin
      if (global_reset) begin
         r_pat    <= '0;
         r_key    <= '0;
         r_bend   <= '0;
         r_carry  <= '0;
         r_subkey <= '0;
         r_qlt    <= '0;
         r_bsy    <= 1'b0;
      end else begin
         r_pat    <= best_pat;
         r_key    <= best_key;
         r_bend   <= best_bend;
         r_carry  <= best_carry;
         r_subkey <= best_subkey;
         r_qlt    <= best_qlt;
         r_bsy    <= best_bsy;
      end
   end

   // Qualification and candidate selection; ties on rank keep the older candidate
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      nxt_pat    = c_pat;
      nxt_key    = c_key;
      nxt_bend   = c_bend;
      nxt_carry  = c_carry;
      nxt_subkey = c_subkey;
      nxt_qlt    = c_qlt;

      hit_ok = !r_bsy && (r_pat[6:4] >= hit_thresh) && (r_pat[3:0] >= pid_thresh)
               && (r_key[7:5] != 3'd7);
      better = r_pat[6:1] > c_pat[6:1];
      take   = hit_ok && ((state == S_IDLE) || ((state == S_DRIFT) && better));

      // A lowered drift_dly mid-window ends the window rather than wrapping the counter
      emit   = ((state == S_IDLE) && hit_ok && (drift_dly == 3'd0))
               || ((state == S_DRIFT) && (drift_cnt >= drift_dly));

      if (take) begin
         nxt_pat    = r_pat;
         nxt_key    = r_key;
         nxt_bend   = r_bend;
         nxt_carry  = r_carry;
         nxt_subkey = r_subkey;
         nxt_qlt    = r_qlt;
      end
   end

   busy_group_mask u_mask (
      .grp  (nxt_key[7:5]),
      .mask (nxt_mask)
   );

   // Drift/hold FSM with registered CLCT, busy mask and lost-hit counter
   always_ff @(posedge clock) begin
      if (global_reset) begin
         state       <= S_IDLE;
         drift_cnt   <= '0;
         hold_cnt    <= '0;
         c_pat       <= '0;
         c_key       <= '0;
         c_bend      <= '0;
         c_carry     <= '0;
         c_subkey    <= '0;
         c_qlt       <= '0;
         clct_vld    <= 1'b0;
         clct_pat    <= '0;
         clct_key    <= '0;
         clct_bend   <= '0;
         clct_carry  <= '0;
         clct_subkey <= '0;
         clct_qlt    <= '0;
         bsy_out     <= '0;
         lost_cnt    <= '0;
      end else begin
         clct_vld <= 1'b0;
         c_pat    <= nxt_pat;
         c_key    <= nxt_key;
         c_bend   <= nxt_bend;
         c_carry  <= nxt_carry;
         c_subkey <= nxt_subkey;
         c_qlt    <= nxt_qlt;

         case (state)
            S_IDLE: begin
               if (hit_ok && (drift_dly != 3'd0)) begin
                  state     <= S_DRIFT;
                  drift_cnt <= 3'd1;
               end
            end
            S_DRIFT: begin
               if (!emit) drift_cnt <= drift_cnt + 3'd1;
            end
            S_HOLD: begin
               // Hits during busy, including the exit cycle, are dropped and counted
               if (hit_ok && (lost_cnt != 8'hFF)) lost_cnt <= lost_cnt + 8'd1;
               if (hold_cnt <= 4'd1) begin
                  state   <= S_IDLE;
                  bsy_out <= '0;
               end else begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (emit) begin
            state       <= S_HOLD;
            hold_cnt    <= busy_width;
            clct_vld    <= 1'b1;
            clct_pat    <= nxt_pat;
            clct_key    <= nxt_key;
            clct_bend   <= nxt_bend;
            clct_carry  <= nxt_carry;
            clct_subkey <= nxt_subkey;
            clct_qlt    <= nxt_qlt;
            bsy_out     <= nxt_mask;
         end
      end
   end

endmodule
